// File: rtl/ex_mdu.sv
// ex_mdu: sequential RISC-V M-extension multiply/divide unit for the EX stage.
// Define ARVI_MDU_REUSE_EN to keep the last full result for paired-op reuse.
module ex_mdu #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 2,
    parameter int DIV_BPC = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_res
);
    // state  | meaning
    // S_IDLE | waiting for a request
    // S_MUL  | shift-add iterations, MUL_BPC multiplier bits per cycle
    // S_DIV  | restoring-division iterations, DIV_BPC quotient bits per cycle
    // S_DONE | result presented for one cycle; may accept the next request

    localparam int MUL_ITER = XLEN / MUL_BPC;
    localparam int DIV_ITER = XLEN / DIV_BPC;
    localparam int MAX_ITER = (MUL_ITER > DIV_ITER) ? MUL_ITER : DIV_ITER;
    localparam int CW       = $clog2(MAX_ITER + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [2*XLEN-1:0] r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvsr;
    logic [XLEN-1:0]   r_res;

    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic              w_hit;
    logic              w_fast;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_hit_res;
    logic [XLEN-1:0]   w_fast_res;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_fin;
    logic [XLEN-1:0]   w_rem_fin;
    logic [XLEN:0]     w_trial;

    // Request decode: MUL (f3=000) is treated as unsigned, its low half is the same either way
    assign w_ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept   = i_valid && w_ready && !i_kill;
    assign w_is_div   = i_f3[2];
    assign w_a_sgn    = w_is_div ? ~i_f3[0] : ((i_f3[1:0] == 2'b01) || (i_f3[1:0] == 2'b10));
    assign w_b_sgn    = w_is_div ? ~i_f3[0] : (i_f3[1:0] == 2'b01);
    assign w_a_neg    = w_a_sgn && i_rs1[XLEN-1];
    assign w_b_neg    = w_b_sgn && i_rs2[XLEN-1];
    assign w_a_abs    = w_a_neg ? (~i_rs1 + 1'b1) : i_rs1;
    assign w_b_abs    = w_b_neg ? (~i_rs2 + 1'b1) : i_rs2;
    assign w_div_zero = w_is_div && (i_rs2 == '0);
    assign w_div_ovf  = w_is_div && !i_f3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_fast     = w_special || w_hit;
    assign w_last     = (r_cnt == '0);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = i_f3[1] ? i_rs1 : '1;
        end else if (w_div_ovf) begin
            w_special_res = i_f3[1] ? '0 : i_rs1;
        end
        w_fast_res = w_special ? w_special_res : w_hit_res;
    end

    always_comb begin
        w_acc_nxt = r_acc;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (r_mplier[j]) begin
                w_acc_nxt = w_acc_nxt + (r_mcand << j);
            end
        end
        w_prod = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    end

    // Dividend bits shift out of r_quo into the partial remainder while quotient bits shift in
    always_comb begin
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        w_trial   = '0;
        for (int j = 0; j < DIV_BPC; j++) begin
            w_trial   = {w_rem_nxt, w_quo_nxt[XLEN-1]};
            w_quo_nxt = {w_quo_nxt[XLEN-2:0], 1'b0};
            if (w_trial >= {1'b0, r_dvsr}) begin
                w_trial      = w_trial - {1'b0, r_dvsr};
                w_quo_nxt[0] = 1'b1;
            end
            w_rem_nxt = w_trial[XLEN-1:0];
        end
        w_quo_fin = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
        w_rem_fin = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (w_fast) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = w_is_div ? S_DIV : S_MUL;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (i_kill) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = w_ready;
        o_valid = (r_state == S_DONE);
        o_busy  = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
        o_res   = r_res;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_res    <= '0;
        end else if (w_accept) begin
            r_op     <= i_f3[1:0];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= w_is_div ? CW'(DIV_ITER - 1) : CW'(MUL_ITER - 1);
            r_mcand  <= {{XLEN{1'b0}}, w_a_abs};
            r_acc    <= '0;
            r_mplier <= w_b_abs;
            r_quo    <= w_a_abs;
            r_rem    <= '0;
            r_dvsr   <= w_b_abs;
            if (w_fast) begin
                r_res <= w_fast_res;
            end
        end else if ((r_state == S_MUL) && !i_kill) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MUL_BPC;
            r_mplier <= r_mplier >> MUL_BPC;
            r_cnt    <= r_cnt - 1'b1;
            if (w_last) begin
                r_res <= (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
            end
        end else if ((r_state == S_DIV) && !i_kill) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_res <= r_op[1] ? w_rem_fin : w_quo_fin;
            end
        end
    end

`ifdef ARVI_MDU_REUSE_EN
    logic              r_c_vld;
    logic              r_c_div;
    logic [1:0]        r_c_sgn;
    logic [1:0]        r_sgn;
    logic [XLEN-1:0]   r_a_raw;
    logic [XLEN-1:0]   r_b_raw;
    logic [XLEN-1:0]   r_c_a;
    logic [XLEN-1:0]   r_c_b;
    logic [XLEN-1:0]   r_c_lo;
    logic [XLEN-1:0]   r_c_hi;

    // A MUL request may reuse any stored product: its low half does not depend on signedness
    assign w_hit = r_c_vld && (r_c_div == w_is_div) && (r_c_a == i_rs1) && (r_c_b == i_rs2)
                 && ((r_c_sgn == {w_a_sgn, w_b_sgn}) || (!w_is_div && (i_f3[1:0] == 2'b00)));

    always_comb begin
        if (w_is_div) begin
            w_hit_res = i_f3[1] ? r_c_hi : r_c_lo;
        end else begin
            w_hit_res = (i_f3[1:0] == 2'b00) ? r_c_lo : r_c_hi;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_c_vld <= 1'b0;
            r_c_div <= 1'b0;
            r_c_sgn <= '0;
            r_sgn   <= '0;
            r_a_raw <= '0;
            r_b_raw <= '0;
            r_c_a   <= '0;
            r_c_b   <= '0;
            r_c_lo  <= '0;
            r_c_hi  <= '0;
        end else begin
            if (w_accept) begin
                r_a_raw <= i_rs1;
                r_b_raw <= i_rs2;
                r_sgn   <= {w_a_sgn, w_b_sgn};
            end
            if (i_kill || (w_accept && w_special)) begin
                r_c_vld <= 1'b0;
            end else if ((r_state == S_MUL) && w_last) begin
                r_c_vld <= 1'b1;
                r_c_div <= 1'b0;
                r_c_sgn <= r_sgn;
                r_c_a   <= r_a_raw;
                r_c_b   <= r_b_raw;
                r_c_lo  <= w_prod[XLEN-1:0];
                r_c_hi  <= w_prod[2*XLEN-1:XLEN];
            end else if ((r_state == S_DIV) && w_last) begin
                r_c_vld <= 1'b1;
                r_c_div <= 1'b1;
                r_c_sgn <= r_sgn;
                r_c_a   <= r_a_raw;
                r_c_b   <= r_b_raw;
                r_c_lo  <= w_quo_fin;
                r_c_hi  <= w_rem_fin;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and random checks of ex_mdu results, latency, kill and reset.
module tb_ex_mdu;
`ifdef ARVI_MDU_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif
    localparam int LAT_MUL = 17;
    localparam int LAT_DIV = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        ready;
    logic        busy;
    logic        ovalid;
    logic [31:0] res;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(32), .MUL_BPC(2), .DIV_BPC(1)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_f3    (f3),
        .i_rs1   (rs1),
        .i_rs2   (rs2),
        .i_kill  (kill),
        .o_ready (ready),
        .o_busy  (busy),
        .o_valid (ovalid),
        .o_res   (res)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] da, db;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        da = a;
        db = b;
        p  = '0;
        case (op)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(da / db);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(da % db);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return LAT_MUL;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_DIV;
    endfunction

    // Drives a request at posedge+1; returns one cycle after the accepting edge.
    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        f3    = op;
        rs1   = a;
        rs2   = b;
        #1;
        chk("accept ready", 32'(ready), 32'd1);
        chk("accept busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        exp_t e;
        int   cyc;
        e.res = exp_res;
        e.lat = exp_lat;
        e.tag = tag;
        sb_q.push_back(e);
        start(op, a, b);
        cyc = 1;
        while (ovalid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb_q.pop_front();
        chk({e.tag, " valid"}, 32'(ovalid), 32'd1);
        chk({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
        chk({e.tag, " result"}, res, e.res);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (ovalid === 1'b1) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        kill  = 1'b0;
        f3    = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst valid", 32'(ovalid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst res", res, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue("mul 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL);
        @(posedge clk);
        #1;
        chk("valid one cycle", 32'(ovalid), 32'd0);
        chk("res held", res, 32'hFFFF_FFEB);
        issue("mulhu max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);

        issue("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV);
        issue("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, REUSE ? 1 : LAT_DIV);
        issue("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, LAT_DIV);
        issue("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, REUSE ? 1 : LAT_DIV);
        issue("div 100/7", 3'b100, 32'd100, 32'd7, 32'd14, LAT_DIV);
        issue("rem 100/7", 3'b110, 32'd100, 32'd7, 32'd2, REUSE ? 1 : LAT_DIV);

        issue("mulh min*3", 3'b001, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, LAT_MUL);
        issue("mul min*3", 3'b000, 32'h8000_0000, 32'd3, 32'h8000_0000, REUSE ? 1 : LAT_MUL);
        issue("mulhsu -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL);

        issue("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        issue("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        issue("div after special", 3'b100, 32'd1000, 32'd3, 32'd333, LAT_DIV);

        // Kill in the middle of a divide
        @(posedge clk);
        #1;
        start(3'b100, 32'd1000, 32'd7);
        repeat (8) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill ready", 32'(ready), 32'd1);
        chk("kill busy", 32'(busy), 32'd0);
        chk("kill valid", 32'(ovalid), 32'd0);
        watch_no_valid("kill no valid", 40);
        issue("mul 3*4", 3'b000, 32'd3, 32'd4, 32'd12, LAT_MUL);

        // Kill together with a request in IDLE/DONE cancels the accept
        valid = 1'b1;
        kill  = 1'b1;
        f3    = 3'b100;
        rs1   = 32'd9;
        rs2   = 32'd0;
        #1;
        chk("idle kill busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        kill  = 1'b0;
        chk("idle kill ready", 32'(ready), 32'd1);
        watch_no_valid("idle kill no valid", 20);
        chk("idle kill res held", res, 32'd12);

        for (int k = 0; k < 10; k++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (k == 4) ? 32'd0 : $urandom;
            if (k == 7) rb = 32'(ra[3:0]) + 32'd1;
            issue($sformatf("rand%0d f3=%0d", k, rf), rf, ra, rb, ref_mdu(rf, ra, rb),
                  lat_of(rf, ra, rb));
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a multiply discards it
        start(3'b001, 32'd123, 32'd456);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midrst ready", 32'(ready), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst res", res, 32'd0);
        watch_no_valid("midrst no valid", 25);
        issue("divu after rst", 3'b101, 32'd100, 32'd7, 32'd14, LAT_DIV);
        issue("remu after rst", 3'b111, 32'd100, 32'd7, 32'd2, REUSE ? 1 : LAT_DIV);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Parametrised sequential RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the EX stage.
- Replaces the separate start/done multiplier and divider pair with one unit that has:
  - a valid/ready handshake;
  - configurable bits-per-cycle;
  - kill support;
  - early-out for special cases.
- EX muxes o_res against the ALU result and derives its stall from o_busy.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of MUL_BPC and DIV_BPC.
- MUL_BPC, 2, multiplier bits retired per cycle (shift-add, 1..4).
- DIV_BPC, 1, quotient bits produced per cycle (restoring, 1..2).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_valid  in  1  request strobe; sampled only when o_ready=1.
- i_f3  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1  in  XLEN  operand A / dividend.
- i_rs2  in  XLEN  operand B / divisor.
- i_kill  in  1  abort the in-flight operation (pipeline flush).
- o_ready  out  1  unit idle; can accept a request this cycle.
- o_busy  out  1  an operation is accepted but not yet delivered.
- o_valid  out  1  one-cycle pulse; o_res is valid.
- o_res  out  XLEN  result; held stable until the next accept.

Behaviour:
- Reset (i_rst=0 at an edge):
  - state ← IDLE; o_valid=0, o_busy=0, o_res=0, o_ready=1.
  - Iteration counter and internal registers cleared.
  - Reset mid-operation discards the operation; no o_valid.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accept occurs when i_valid && o_ready. Operands and f3 are latched, and absolute values are taken per signedness.
  - Multiply goes to MUL.
  - Divide with i_rs2=0 goes straight to DONE:
    - DIV/DIVU result is all-ones;
    - REM/REMU result is i_rs1.
  - Signed overflow (i_rs1=0x80..0, i_rs2=all-ones, f3=100/110) goes straight to DONE:
    - DIV result is i_rs1;
    - REM result is 0.
  - Any other divide goes to DIV.
- MUL:
  - XLEN/MUL_BPC cycles; each cycle adds MUL_BPC partial products into a 2*XLEN accumulator.
  - Then go to DONE; the final sign correction is applied on the DONE transition.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Signedness per operand:
    - MULHSU: rs1 signed, rs2 unsigned;
    - MULH: both signed;
    - MULHU: both unsigned;
    - MUL: either interpretation (low half identical).
- DIV:
  - XLEN/DIV_BPC cycles of restoring division on magnitudes, then DONE.
  - Sign rules: quotient negated iff operand signs differ (signed ops); remainder takes the dividend sign.
- DONE:
  - o_valid=1 for exactly one cycle, with o_res updated.
  - Next state is IDLE; o_ready=1 in DONE.
  - Back-to-back: a new accept in DONE goes directly to the next operation state. Zero bubble.
- Latency, accept edge to o_valid high:
  - MUL: XLEN/MUL_BPC+1 cycles (17 at defaults);
  - DIV: XLEN/DIV_BPC+1 cycles (33 at defaults);
  - special-case divides: 1 cycle.
- o_ready = (state==IDLE) || (state==DONE).
- o_busy = accept-pending or state in {MUL, DIV}.
  - o_busy is combinationally high in the accept cycle, so EX stalls immediately.
- i_kill:
  - In MUL or DIV: go to IDLE next edge, no o_valid.
  - In IDLE or DONE: cancels any same-cycle accept; an o_valid already high is still presented.
- i_valid while busy is ignored; the requester must hold it.
- o_res retains its last value outside DONE.

Optional Feature:
- Macro: ARVI_MDU_REUSE_EN.
- When defined:
  - The unit keeps the last completed operands, op class (mul/div) and signedness, plus the full 2*XLEN product or the quotient+remainder pair.
  - An accept whose rs1, rs2, class and signedness match the stored entry goes straight to DONE with latency 1, and returns the other half.
  - Pairs covered: MULH/MULHSU/MULHU followed by MUL; DIV followed by REM; DIVU followed by REMU.
  - The entry is invalidated by reset, i_kill, and special-case completions.
- When undefined: no cache storage; every request runs full latency.

Test Plan:
- Reset held 2 cycles → o_ready=1, o_valid=0, o_busy=0, o_res=0.
- MUL rs1=7, rs2=-3 → o_valid after 17 cycles, o_res=0xFFFFFFEB. Then MULHU rs1=rs2=0xFFFFFFFF → o_res=0xFFFFFFFE.
- DIV -7/2 → o_res=0xFFFFFFFD after 33 cycles. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF after 1 cycle. REMU 5/0 → 5. DIV 0x80000000/-1 → 0x80000000. REM 0x80000000/-1 → 0.
- DIV issued, i_kill pulsed at cycle 10 → no o_valid, o_ready=1 next cycle. Then MUL 3*4 → 12 with normal latency.
- With ARVI_MDU_REUSE_EN:
  - DIV 100/7 then REM 100/7 back-to-back in DONE → second o_valid 1 cycle after accept, o_res=2.
  - Without the macro → 33 cycles.
